shift_arbiter: RTL and testbench

Shares the single 16-bit barrel shifter (ROL/SLL/ROR/SRL) between two requesters, e.g. the execute ALU path and the address/branch helper path. It arbitrates round-robin with a valid/ready handshake per requester and drives the shared shifter's In/Cnt/Op from the winner. Results are buffered in a small output FIFO, each entry tagged with the requester ID. This decouples the shifter from downstream backpressure.

---
 rtl/shift_arbiter.sv | 159 +++++++++++++++
 tb/tb_shift_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
// Purpose: shares one 16-bit barrel shifter (ROL/SLL/ROR/SRL) between two
// requesters with round-robin arbitration, and buffers the tagged results in a
// small FIFO so that downstream backpressure never stalls the shifter itself.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   reqN_valid/in/cnt/op      requester N operation (op: 00 ROL 01 SLL 10 ROR 11 SRL)
//   reqN_ready                combinational grant to requester N this cycle
//   out_valid/data/tag        FIFO head (data/tag forced to 0 when empty)
//   out_ready                 consumer pops the head when out_valid=1
//   count                     FIFO occupancy
// -----------------------------------------------------------------------------
module shift_arbiter #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [15:0]        req0_in,
    input  logic [3:0]         req0_cnt,
    input  logic [1:0]         req0_op,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [15:0]        req1_in,
    input  logic [3:0]         req1_cnt,
    input  logic [1:0]         req1_op,
    output logic               req1_ready,
    output logic               out_valid,
    output logic [15:0]        out_data,
    output logic               out_tag,
    input  logic               out_ready,
    output logic [PTR_W:0]     count
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = PTR_W + 1;

    // Shared barrel shifter; rotates use a doubled operand so cnt=0 is a pass-through.
    function automatic logic [DATA_W-1:0] f_shift(
        input logic [DATA_W-1:0] a,
        input logic [3:0]        c,
        input logic [1:0]        op
    );
        logic [2*DATA_W-1:0] dbl;
        logic [DATA_W-1:0]   res;
        dbl = {a, a};
        res = a;
        case (op)
            2'b00: begin
                dbl = dbl << c;
                res = dbl[2*DATA_W-1:DATA_W];
            end
            2'b01: res = a << c;
            2'b10: begin
                dbl = dbl >> c;
                res = dbl[DATA_W-1:0];
            end
            default: res = a >> c;
        endcase
        return res;
    endfunction

    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic              r_mem_tag  [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_prio;

    logic              w_space;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_push;
    logic              w_pop;
    logic              w_sel;
    logic [DATA_W-1:0] w_in;
    logic [3:0]        w_cnt;
    logic [1:0]        w_op;
    logic [DATA_W-1:0] w_result;

    // Space is judged on occupancy only; a same-cycle pop never frees a slot.
    assign w_space = (r_count < CNT_W'(DEPTH));

    // Round-robin grant; rst gates the readys so they drop without a clock edge.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst && w_space) begin
            if (req0_valid && req1_valid) begin
                w_gnt0 = ~r_prio;
                w_gnt1 = r_prio;
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign w_push     = w_gnt0 | w_gnt1;
    assign w_sel      = w_gnt1;

    // Winner's operands drive the shifter in the grant cycle.
    always_comb begin
        w_in  = req0_in;
        w_cnt = req0_cnt;
        w_op  = req0_op;
        if (w_sel) begin
            w_in  = req1_in;
            w_cnt = req1_cnt;
            w_op  = req1_op;
        end
    end

    assign w_result = f_shift(w_in, w_cnt, w_op);

    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid & out_ready;

    // Pointers, occupancy and priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_prio   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_prio   <= ~w_sel;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Result storage; contents are only observable through a valid head.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_result;
            r_mem_tag[r_wr_ptr]  <= w_sel;
        end
    end

    assign out_data = out_valid ? r_mem_data[r_rd_ptr] : '0;
    assign out_tag  = out_valid ? r_mem_tag[r_rd_ptr]  : 1'b0;
    assign count    = r_count;

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter: directed stimulus with hand-computed results; accepted
// operations push their expected {tag,data} into a scoreboard queue and an
// independent monitor pops and compares whenever the DUT pops its FIFO head.
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [15:0] req0_in;
    logic [3:0]  req0_cnt;
    logic [1:0]  req0_op;
    logic        req0_ready;
    logic        req1_valid;
    logic [15:0] req1_in;
    logic [3:0]  req1_cnt;
    logic [1:0]  req1_op;
    logic        req1_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_tag;
    logic        out_ready;
    logic [1:0]  count;

    int checks   = 0;
    int failures = 0;

    logic [16:0] exp0;
    logic [16:0] exp1;
    logic [16:0] sb[$];

    localparam logic [1:0] ROL = 2'b00;
    localparam logic [1:0] SLL = 2'b01;
    localparam logic [1:0] ROR = 2'b10;
    localparam logic [1:0] SRL = 2'b11;

    shift_arbiter #(.DEPTH(2), .PTR_W(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_in    (req0_in),
        .req0_cnt   (req0_cnt),
        .req0_op    (req0_op),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_in    (req1_in),
        .req1_cnt   (req1_cnt),
        .req1_op    (req1_op),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_ready  (out_ready),
        .count      (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [15:0] a, input logic [3:0] c,
                        input logic [1:0] op, input logic [15:0] res);
        req0_valid = v; req0_in = a; req0_cnt = c; req0_op = op;
        exp0 = {1'b0, res};
    endtask

    task automatic set1(input logic v, input logic [15:0] a, input logic [3:0] c,
                        input logic [1:0] op, input logic [15:0] res);
        req1_valid = v; req1_in = a; req1_cnt = c; req1_op = op;
        exp1 = {1'b1, res};
    endtask

    // Stop requesting, pop everything, bounded wait for empty.
    task automatic drain();
        int n;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b1;
        n = 0;
        @(negedge clk);
        while (count != 2'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(count), 32'd0);
        tick();
    endtask

    // Accept tracker: record the expected result of every transfer.
    always @(negedge clk) begin
        if (!rst) begin
            check("rdy0_implies_valid", 32'(req0_ready & ~req0_valid), 32'd0);
            check("rdy1_implies_valid", 32'(req1_ready & ~req1_valid), 32'd0);
            if (req0_valid && req0_ready) sb.push_back(exp0);
            if (req1_valid && req1_ready) sb.push_back(exp1);
        end
    end

    // Monitor: compare each popped head against the scoreboard.
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_pop", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(e[15:0]));
                    check("out_tag",  32'(out_tag),  32'(e[16]));
                end
            end else if (!out_valid) begin
                check("empty_head_zero", 32'({out_tag, out_data}), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        set0(1'b1, 16'h0000, 4'd0, ROL, 16'h0000);
        set1(1'b1, 16'h0000, 4'd0, ROL, 16'h0000);
        #2;
        check("rst_ready0",    32'(req0_ready), 32'd0);
        check("rst_ready1",    32'(req1_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_count",     32'(count),      32'd0);
        check("rst_out_data",  32'(out_data),   32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        rst = 1'b0;

        // Single req0 ROL, one-cycle latency through an empty FIFO.
        out_ready = 1'b1;
        set0(1'b1, 16'h8001, 4'd1, ROL, 16'h0003);
        @(negedge clk);
        check("t1_ready0", 32'(req0_ready), 32'd1);
        check("t1_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("t1_out_valid", 32'(out_valid), 32'd1);
        tick();
        @(negedge clk);
        check("t1_count_after_pop", 32'(count), 32'd0);
        tick();

        // req1 sequence over the other three ops plus cnt=0.
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set1(1'b1, 16'h00FF, 4'd4,  SLL, 16'h0FF0);
                1: set1(1'b1, 16'h0001, 4'd1,  ROR, 16'h8000);
                2: set1(1'b1, 16'h8000, 4'd15, SRL, 16'h0001);
                default: set1(1'b1, 16'h1234, 4'd0, ROL, 16'h1234);
            endcase
            @(negedge clk);
            check("t2_ready1", 32'(req1_ready), 32'd1);
            tick();
        end
        drain();

        // Fresh reset, continuous dual request: alternating grants from req0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        set0(1'b1, 16'h0003, 4'd1, ROR, 16'h8001);
        set1(1'b1, 16'hF000, 4'd4, SRL, 16'h0F00);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t3_ready0", 32'(req0_ready), 32'((i % 2) == 0));
            check("t3_ready1", 32'(req1_ready), 32'((i % 2) == 1));
            tick();
        end
        drain();

        // Backpressure: fill, pop-only cycle, then a single push resumes.
        out_ready = 1'b0;
        set0(1'b1, 16'h0001, 4'd3, SLL, 16'h0008);
        set1(1'b1, 16'h00F0, 4'd8, ROL, 16'hF000);
        @(negedge clk);
        check("t4_a_ready0", 32'(req0_ready), 32'd1);
        check("t4_a_ready1", 32'(req1_ready), 32'd0);
        tick();
        @(negedge clk);
        check("t4_b_ready0", 32'(req0_ready), 32'd0);
        check("t4_b_ready1", 32'(req1_ready), 32'd1);
        tick();
        @(negedge clk);
        check("t4_full_count",  32'(count),      32'd2);
        check("t4_full_ready0", 32'(req0_ready), 32'd0);
        check("t4_full_ready1", 32'(req1_ready), 32'd0);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_poponly_ready0", 32'(req0_ready), 32'd0);
        check("t4_poponly_ready1", 32'(req1_ready), 32'd0);
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("t4_resume_count",  32'(count),      32'd1);
        check("t4_resume_ready0", 32'(req0_ready), 32'd1);
        check("t4_resume_ready1", 32'(req1_ready), 32'd0);
        tick();
        @(negedge clk);
        check("t4_refull_count", 32'(count), 32'd2);
        tick();
        drain();

        // Streaming through an empty FIFO: occupancy never exceeds one.
        out_ready = 1'b1;
        set0(1'b1, 16'h1234, 4'd4, ROR, 16'h4123);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_ready0", 32'(req0_ready), 32'd1);
            check("t5_count",  32'(count), (i == 0) ? 32'd0 : 32'd1);
            tick();
        end
        drain();

        // Async reset while full with prio pointing at req1.
        out_ready = 1'b0;
        set0(1'b1, 16'h0F0F, 4'd4, SRL, 16'h00F0);
        tick();
        tick();
        @(negedge clk);
        check("t6_full_count", 32'(count), 32'd2);
        set1(1'b1, 16'h0001, 4'd15, SLL, 16'h8000);
        #1;
        rst = 1'b1;
        #1;
        check("t6_async_out_valid", 32'(out_valid),  32'd0);
        check("t6_async_count",     32'(count),      32'd0);
        check("t6_async_ready0",    32'(req0_ready), 32'd0);
        check("t6_async_ready1",    32'(req1_ready), 32'd0);
        check("t6_async_out_data",  32'(out_data),   32'd0);
        sb.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_first_ready0", 32'(req0_ready), 32'd1);
        check("t6_first_ready1", 32'(req1_ready), 32'd0);
        tick();
        drain();

        check("sb_empty_at_end", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
